// File: rtl/sdram_responder.sv
// sdram_responder: chip end of the 16-bit SDR SDRAM bus.
// Decodes host commands, tracks open rows per bank, returns read data after the
// programmed CAS latency, performs byte-masked writes into on-chip BRAM and keeps
// sticky flags for protocol violations seen on the bus.
module sdram_responder #(
    parameter int MEM_AW = 16,
    parameter int TRCD   = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [12:0] sdram_a,
    input  logic [1:0]  sdram_ba,
    input  logic        sdram_ncs,
    input  logic        sdram_nras,
    input  logic        sdram_ncas,
    input  logic        sdram_nwe,
    input  logic        sdram_dqml,
    input  logic        sdram_dqmh,
    input  logic        sdram_cke,
    input  logic [15:0] sdram_dq_i,
    output logic [15:0] sdram_dq_o,
    output logic        sdram_dq_oe,
    output logic [12:0] mode_reg,
    output logic        mode_valid,
    output logic [5:0]  err,
    output logic [15:0] refresh_cnt
);

    // Width of the per-bank ACTIVE->access countdown; must hold TRCD-1.
    localparam int TW = (TRCD > 1) ? $clog2(TRCD) : 1;

    typedef enum logic [2:0] {
        CMD_LOAD    = 3'b000,
        CMD_REFRESH = 3'b001,
        CMD_PRE     = 3'b010,
        CMD_ACT     = 3'b011,
        CMD_WRITE   = 3'b100,
        CMD_READ    = 3'b101,
        CMD_BST     = 3'b110,
        CMD_NOP     = 3'b111
    } cmd_e;

    cmd_e                 cmd;
    logic                 cmdValid;
    logic                 isAct, isRead, isWrite, isPre, isRefresh, isLoad;
    logic                 bankOpen, bankBusy;
    logic [2:0]           casLat;
    logic                 clOk, clBad, useCl3;
    logic [23:0]          fullAddr;
    logic [MEM_AW-1:0]    accAddr;
    logic                 rdEn, wrLo, wrHi;

    logic [3:0]           open_q, open_d;
    logic [3:0][12:0]     row_q, row_d;
    logic [3:0][TW-1:0]   trcd_q, trcd_d;

    logic [12:0]          mode_q, mode_d;
    logic                 modeValid_q, modeValid_d;
    logic [5:0]           err_q, err_d;
    logic [15:0]          refresh_q, refresh_d;

    logic [7:0]           memLo_q [2**MEM_AW];
    logic [7:0]           memHi_q [2**MEM_AW];
    logic [15:0]          rdData_q;

    logic                 v0_q, v0_d;
    logic                 cl3s0_q, cl3s0_d;
    logic                 v1_q, v1_d;
    logic [15:0]          d1_q, d1_d;
    logic [15:0]          dqo_q, dqo_d;
    logic                 oe_q, oe_d;

    // Command decode, addressed bank status and effective CAS latency for this edge.
    always_comb begin
        cmdValid  = reset_n && !sdram_ncs && sdram_cke;
        cmd       = cmd_e'({sdram_nras, sdram_ncas, sdram_nwe});
        isAct     = cmdValid && (cmd == CMD_ACT);
        isRead    = cmdValid && (cmd == CMD_READ);
        isWrite   = cmdValid && (cmd == CMD_WRITE);
        isPre     = cmdValid && (cmd == CMD_PRE);
        isRefresh = cmdValid && (cmd == CMD_REFRESH);
        isLoad    = cmdValid && (cmd == CMD_LOAD);
        bankOpen  = open_q[sdram_ba];
        bankBusy  = (trcd_q[sdram_ba] != '0);
        fullAddr  = {sdram_ba, sdram_a[8:0], row_q[sdram_ba]};
        accAddr   = MEM_AW'(fullAddr);
        casLat    = mode_q[6:4];
        clOk      = modeValid_q && ((casLat == 3'd2) || (casLat == 3'd3));
        useCl3    = clOk && (casLat == 3'd3);
        clBad     = !clOk || (mode_q[2:0] != 3'd0);
        rdEn      = isRead && bankOpen;
        wrLo      = isWrite && bankOpen && !sdram_dqml;
        wrHi      = isWrite && bankOpen && !sdram_dqmh;
    end

    // Bank bookkeeping: open flags, latched rows and the tRCD countdowns.
    always_comb begin
        open_d = open_q;
        row_d  = row_q;
        trcd_d = trcd_q;
        for (int i = 0; i < 4; i++) begin
            if (trcd_q[i] != '0) begin
                trcd_d[i] = trcd_q[i] - TW'(1);
            end
        end
        if (isAct) begin
            open_d[sdram_ba] = 1'b1;
            row_d[sdram_ba]  = sdram_a;
            trcd_d[sdram_ba] = TW'(TRCD - 1);
        end
        if ((isRead || isWrite) && bankOpen && sdram_a[10]) begin
            open_d[sdram_ba] = 1'b0;
        end
        if (isPre) begin
            if (sdram_a[10]) begin
                open_d = '0;
            end else begin
                open_d[sdram_ba] = 1'b0;
            end
        end
    end

    // Mode register, refresh counter and sticky violation flags.
    always_comb begin
        mode_d      = mode_q;
        modeValid_d = modeValid_q;
        refresh_d   = refresh_q;
        err_d       = err_q;
        if (isLoad) begin
            mode_d      = sdram_a;
            modeValid_d = 1'b1;
        end
        if (isRefresh) begin
            refresh_d = refresh_q + 16'd1;
        end
        if ((isRead || isWrite) && !bankOpen) err_d[0] = 1'b1;
        if (isAct && bankOpen)                 err_d[1] = 1'b1;
        if ((isRefresh || isLoad) && (open_q != '0)) err_d[2] = 1'b1;
        if ((isRead || isWrite) && bankOpen && bankBusy) err_d[3] = 1'b1;
        if (isRead && clBad)                   err_d[4] = 1'b1;
        if (isWrite && oe_q)                   err_d[5] = 1'b1;
    end

    // Read return pipeline: stage 0 holds the BRAM word, stage 1 adds the extra CL3 delay.
    always_comb begin
        v0_d    = rdEn;
        cl3s0_d = useCl3;
        v1_d    = v0_q && cl3s0_q;
        d1_d    = rdData_q;
        oe_d    = 1'b0;
        dqo_d   = dqo_q;
        if (v1_q) begin
            oe_d  = 1'b1;
            dqo_d = d1_q;
        end else if (v0_q && !cl3s0_q) begin
            oe_d  = 1'b1;
            dqo_d = rdData_q;
        end
    end

    // Control state registers; CKE low freezes everything except reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            open_q      <= '0;
            row_q       <= '0;
            trcd_q      <= '0;
            mode_q      <= '0;
            modeValid_q <= 1'b0;
            err_q       <= '0;
            refresh_q   <= '0;
            v0_q        <= 1'b0;
            cl3s0_q     <= 1'b0;
            v1_q        <= 1'b0;
            d1_q        <= '0;
            dqo_q       <= '0;
            oe_q        <= 1'b0;
        end else if (sdram_cke) begin
            open_q      <= open_d;
            row_q       <= row_d;
            trcd_q      <= trcd_d;
            mode_q      <= mode_d;
            modeValid_q <= modeValid_d;
            err_q       <= err_d;
            refresh_q   <= refresh_d;
            v0_q        <= v0_d;
            cl3s0_q     <= cl3s0_d;
            v1_q        <= v1_d;
            d1_q        <= d1_d;
            dqo_q       <= dqo_d;
            oe_q        <= oe_d;
        end
    end

    // Byte-lane BRAM with a registered read port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wrLo) memLo_q[accAddr] <= sdram_dq_i[7:0];
        if (wrHi) memHi_q[accAddr] <= sdram_dq_i[15:8];
        if (rdEn) rdData_q <= {memHi_q[accAddr], memLo_q[accAddr]};
    end

    assign sdram_dq_o  = dqo_q;
    assign sdram_dq_oe = oe_q;
    assign mode_reg    = mode_q;
    assign mode_valid  = modeValid_q;
    assign err         = err_q;
    assign refresh_cnt = refresh_q;

endmodule

// File: tb/tb_sdram_responder.sv
// tb_sdram_responder: table-driven write/read vectors plus hand-written sequences
// for CAS latency, violation flags, back-to-back reads and reset during a burst.
// Read beats are predicted into a queue when the READ is driven and retired by a
// monitor on the falling edge.
module tb_sdram_responder;

    localparam logic [2:0] C_LOAD = 3'b000;
    localparam logic [2:0] C_REF  = 3'b001;
    localparam logic [2:0] C_PRE  = 3'b010;
    localparam logic [2:0] C_ACT  = 3'b011;
    localparam logic [2:0] C_WR   = 3'b100;
    localparam logic [2:0] C_RD   = 3'b101;
    localparam logic [2:0] C_NOP  = 3'b111;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [12:0] sdram_a;
    logic [1:0]  sdram_ba;
    logic        sdram_ncs, sdram_nras, sdram_ncas, sdram_nwe;
    logic        sdram_dqml, sdram_dqmh, sdram_cke;
    logic [15:0] sdram_dq_i, sdram_dq_o;
    logic        sdram_dq_oe;
    logic [12:0] mode_reg;
    logic        mode_valid;
    logic [5:0]  err;
    logic [15:0] refresh_cnt;

    typedef struct {
        int          due;
        logic [15:0] data;
    } beat_t;

    typedef struct {
        logic [1:0]  ba;
        logic [12:0] row;
        logic [8:0]  col;
        logic [15:0] wdata;
        logic        dqml;
        logic        dqmh;
        logic [15:0] expRd;
    } vec_t;

    beat_t sb[$];
    vec_t  vecs[8];
    int    checks = 0;
    int    errors = 0;
    int    edgeCnt = 0;
    bit    monEn = 1'b0;
    int    curCl = 2;

    sdram_responder #(.MEM_AW(16), .TRCD(2)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sdram_a    (sdram_a),
        .sdram_ba   (sdram_ba),
        .sdram_ncs  (sdram_ncs),
        .sdram_nras (sdram_nras),
        .sdram_ncas (sdram_ncas),
        .sdram_nwe  (sdram_nwe),
        .sdram_dqml (sdram_dqml),
        .sdram_dqmh (sdram_dqmh),
        .sdram_cke  (sdram_cke),
        .sdram_dq_i (sdram_dq_i),
        .sdram_dq_o (sdram_dq_o),
        .sdram_dq_oe(sdram_dq_oe),
        .mode_reg   (mode_reg),
        .mode_valid (mode_valid),
        .err        (err),
        .refresh_cnt(refresh_cnt)
    );

    // Free-running 10-time-unit clock.
    always #5 clk = ~clk;

    // Count rising edges so read beats can be scheduled by edge number.
    always @(posedge clk) edgeCnt <= edgeCnt + 1;

    // Retire predicted read beats: DQ must be driven exactly on scheduled cycles.
    always @(negedge clk) begin
        if (monEn) begin
            logic        expOe;
            logic [15:0] expData;
            expOe   = 1'b0;
            expData = '0;
            while (sb.size() > 0 && sb[0].due < edgeCnt) begin
                checks++;
                errors++;
                $display("[TB] FAIL beat_missed edge %0d: got none expected 0x%0h due %0d",
                         edgeCnt, sb[0].data, sb[0].due);
                void'(sb.pop_front());
            end
            if (sb.size() > 0 && sb[0].due == edgeCnt) begin
                expOe   = 1'b1;
                expData = sb[0].data;
                void'(sb.pop_front());
            end
            checks++;
            if (sdram_dq_oe !== expOe) begin
                errors++;
                $display("[TB] FAIL beat_oe edge %0d: got %b expected %b", edgeCnt, sdram_dq_oe, expOe);
            end
            if (expOe) begin
                checks++;
                if (sdram_dq_o !== expData) begin
                    errors++;
                    $display("[TB] FAIL beat_data edge %0d: got 0x%0h expected 0x%0h",
                             edgeCnt, sdram_dq_o, expData);
                end
            end
        end
    end

    function automatic logic [12:0] colAddr(input logic [8:0] col, input logic ap);
        return {2'b00, ap, 1'b0, col};
    endfunction

    // Drive one command for the next rising edge.
    task automatic applyStimulus(input logic [2:0] cmd, input logic [1:0] ba, input logic [12:0] a,
                                 input logic [15:0] dq, input logic dqml, input logic dqmh);
        @(posedge clk);
        #1;
        sdram_ncs  = 1'b0;
        {sdram_nras, sdram_ncas, sdram_nwe} = cmd;
        sdram_ba   = ba;
        sdram_a    = a;
        sdram_dq_i = dq;
        sdram_dqml = dqml;
        sdram_dqmh = dqmh;
    endtask

    task automatic nop(input int n);
        repeat (n) applyStimulus(C_NOP, 2'd0, 13'd0, 16'd0, 1'b1, 1'b1);
    endtask

    // Issue a READ and predict its beat CL-1 edges after the command edge.
    task automatic doRead(input logic [1:0] ba, input logic [8:0] col, input logic ap,
                          input logic [15:0] expData, input int cl);
        beat_t b;
        applyStimulus(C_RD, ba, colAddr(col, ap), 16'd0, 1'b1, 1'b1);
        b.due  = edgeCnt + cl;
        b.data = expData;
        sb.push_back(b);
    endtask

    // Hold reset for n edges; beats scheduled at or after the reset edge are cancelled.
    task automatic applyReset(input int n);
        @(posedge clk);
        #1;
        reset_n    = 1'b0;
        sdram_ncs  = 1'b1;
        {sdram_nras, sdram_ncas, sdram_nwe} = C_NOP;
        while (sb.size() > 0 && sb[$].due > edgeCnt) void'(sb.pop_back());
        repeat (n) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        vecs[0] = '{2'd0, 13'd5,      9'd3,     16'hA55A, 1'b0, 1'b0, 16'hA55A};
        vecs[1] = '{2'd0, 13'd5,      9'd3,     16'h1234, 1'b1, 1'b0, 16'h125A};
        vecs[2] = '{2'd0, 13'd5,      9'd3,     16'hFFFF, 1'b0, 1'b1, 16'h12FF};
        vecs[3] = '{2'd0, 13'd5,      9'd3,     16'h0000, 1'b1, 1'b1, 16'h12FF};
        vecs[4] = '{2'd1, 13'd100,    9'd7,     16'hBEEF, 1'b0, 1'b0, 16'hBEEF};
        vecs[5] = '{2'd3, 13'h1FFF,   9'h1FF,   16'hC0DE, 1'b0, 1'b0, 16'hC0DE};
        vecs[6] = '{2'd2, 13'd0,      9'd8,     16'h5AA5, 1'b0, 1'b0, 16'h5AA5};
        vecs[7] = '{2'd0, 13'd0,      9'd0,     16'h00FF, 1'b0, 1'b1, 16'h5AFF};

        reset_n = 1'b0;
        sdram_ncs = 1'b1;
        {sdram_nras, sdram_ncas, sdram_nwe} = C_NOP;
        sdram_cke = 1'b1;
        sdram_a = '0;
        sdram_ba = '0;
        sdram_dq_i = '0;
        sdram_dqml = 1'b1;
        sdram_dqmh = 1'b1;

        applyReset(3);
        monEn = 1'b1;
        checkOutput("reset_oe", {15'd0, sdram_dq_oe}, 16'd0);
        checkOutput("reset_dq", sdram_dq_o, 16'd0);
        checkOutput("reset_mode", {3'd0, mode_reg}, 16'd0);
        checkOutput("reset_mode_valid", {15'd0, mode_valid}, 16'd0);
        checkOutput("reset_err", {10'd0, err}, 16'd0);
        checkOutput("reset_refresh", refresh_cnt, 16'd0);

        applyStimulus(C_LOAD, 2'd0, 13'h220, 16'd0, 1'b1, 1'b1);
        nop(1);
        curCl = 2;
        checkOutput("load_mode_valid", {15'd0, mode_valid}, 16'd1);
        checkOutput("load_mode_reg", {3'd0, mode_reg}, 16'h0220);
        checkOutput("load_err", {10'd0, err}, 16'd0);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(C_ACT, vecs[i].ba, vecs[i].row, 16'd0, 1'b1, 1'b1);
            nop(2);
            applyStimulus(C_WR, vecs[i].ba, colAddr(vecs[i].col, 1'b0), vecs[i].wdata,
                          vecs[i].dqml, vecs[i].dqmh);
            doRead(vecs[i].ba, vecs[i].col, 1'b1, vecs[i].expRd, curCl);
        end
        nop(5);
        checkOutput("table_err", {10'd0, err}, 16'd0);

        applyStimulus(C_LOAD, 2'd0, 13'h230, 16'd0, 1'b1, 1'b1);
        curCl = 3;
        applyStimulus(C_ACT, 2'd0, 13'd5, 16'd0, 1'b1, 1'b1);
        nop(2);
        doRead(2'd0, 9'd3, 1'b1, 16'h12FF, curCl);
        nop(5);
        checkOutput("cl3_mode_reg", {3'd0, mode_reg}, 16'h0230);
        checkOutput("cl3_err", {10'd0, err}, 16'd0);

        applyStimulus(C_RD, 2'd2, colAddr(9'd8, 1'b0), 16'd0, 1'b1, 1'b1);
        nop(4);
        checkOutput("idle_read_err", {10'd0, err}, 16'h0001);

        applyStimulus(C_ACT, 2'd2, 13'd0, 16'd0, 1'b1, 1'b1);
        doRead(2'd2, 9'd8, 1'b1, 16'h5AFF, curCl);
        nop(5);
        checkOutput("trcd_err", {10'd0, err}, 16'h0009);

        applyStimulus(C_ACT, 2'd1, 13'd100, 16'd0, 1'b1, 1'b1);
        applyStimulus(C_REF, 2'd0, 13'd0, 16'd0, 1'b1, 1'b1);
        applyStimulus(C_PRE, 2'd0, 13'h400, 16'd0, 1'b1, 1'b1);
        applyStimulus(C_ACT, 2'd1, 13'd100, 16'd0, 1'b1, 1'b1);
        nop(1);
        checkOutput("refresh_cnt", refresh_cnt, 16'd1);
        checkOutput("refresh_err", {10'd0, err}, 16'h000D);
        applyStimulus(C_ACT, 2'd1, 13'd100, 16'd0, 1'b1, 1'b1);
        applyStimulus(C_PRE, 2'd0, 13'h400, 16'd0, 1'b1, 1'b1);
        nop(1);
        checkOutput("reopen_err", {10'd0, err}, 16'h000F);

        applyStimulus(C_ACT, 2'd0, 13'd5, 16'd0, 1'b1, 1'b1);
        nop(2);
        doRead(2'd0, 9'd3, 1'b0, 16'h12FF, curCl);
        nop(2);
        applyStimulus(C_WR, 2'd0, colAddr(9'd3, 1'b0), 16'hA55A, 1'b0, 1'b0);
        doRead(2'd0, 9'd3, 1'b1, 16'hA55A, curCl);
        nop(5);
        checkOutput("write_oe_err", {10'd0, err}, 16'h002F);

        applyStimulus(C_ACT, 2'd1, 13'd100, 16'd0, 1'b1, 1'b1);
        applyStimulus(C_ACT, 2'd3, 13'h1FFF, 16'd0, 1'b1, 1'b1);
        applyStimulus(C_ACT, 2'd2, 13'd0, 16'd0, 1'b1, 1'b1);
        nop(2);
        doRead(2'd1, 9'd7,   1'b0, 16'hBEEF, curCl);
        doRead(2'd3, 9'h1FF, 1'b0, 16'hC0DE, curCl);
        doRead(2'd2, 9'd8,   1'b0, 16'h5AFF, curCl);
        doRead(2'd1, 9'd7,   1'b0, 16'hBEEF, curCl);
        nop(5);

        doRead(2'd3, 9'h1FF, 1'b0, 16'hC0DE, curCl);
        doRead(2'd1, 9'd7,   1'b0, 16'hBEEF, curCl);
        doRead(2'd2, 9'd8,   1'b0, 16'h5AFF, curCl);
        doRead(2'd3, 9'h1FF, 1'b0, 16'hC0DE, curCl);
        applyReset(2);
        checkOutput("midreset_oe", {15'd0, sdram_dq_oe}, 16'd0);
        checkOutput("midreset_err", {10'd0, err}, 16'd0);
        checkOutput("midreset_mode_valid", {15'd0, mode_valid}, 16'd0);
        checkOutput("midreset_refresh", refresh_cnt, 16'd0);

        applyStimulus(C_ACT, 2'd0, 13'd5, 16'd0, 1'b1, 1'b1);
        nop(2);
        doRead(2'd0, 9'd3, 1'b1, 16'hA55A, 2);
        nop(4);
        checkOutput("nomode_err", {10'd0, err}, 16'h0010);

        applyStimulus(C_LOAD, 2'd0, 13'h220, 16'd0, 1'b1, 1'b1);
        curCl = 2;
        applyStimulus(C_ACT, 2'd1, 13'd100, 16'd0, 1'b1, 1'b1);
        nop(2);
        doRead(2'd1, 9'd7, 1'b1, 16'hBEEF, curCl);
        nop(5);
        checkOutput("retained_err", {10'd0, err}, 16'h0010);

        monEn = 1'b0;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
